// File: rtl/dac_ramp_gen.sv
// Sawtooth/triangle ramp generator for the AD9783 DAC path.
// A fixed-point phase accumulator is stepped between latched signed bounds.
module dac_ramp_gen #(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    on_in,
    input  logic                    mode_in,
    input  logic signed [OUT_W-1:0] minval_in,
    input  logic signed [OUT_W-1:0] maxval_in,
    input  logic [31:0]             stepsize_in,
    output logic signed [OUT_W-1:0] signal_out,
    output logic                    sync_out,
    output logic                    active_out
);

    localparam int ACC_W = OUT_W + FRAC_W;
    localparam int EXT_W = ACC_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } state_t;

    state_t state_q, state_d;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [OUT_W-1:0] lo_q, lo_d;
    logic signed [OUT_W-1:0] hi_q, hi_d;
    logic                    acc_sync_q, acc_sync_d;

    logic signed [ACC_W-1:0] min_acc;
    logic signed [ACC_W-1:0] hi_acc;
    logic signed [EXT_W-1:0] step_x;
    logic signed [EXT_W-1:0] acc_x;
    logic signed [EXT_W-1:0] lo_x;
    logic signed [EXT_W-1:0] hi_x;
    logic signed [EXT_W-1:0] up_x;
    logic signed [EXT_W-1:0] dn_x;
    logic                    cfg_ok;

    assign cfg_ok  = minval_in < maxval_in;
    assign min_acc = {minval_in, {FRAC_W{1'b0}}};
    assign hi_acc  = {hi_q, {FRAC_W{1'b0}}};

    // Two guard bits keep the step sum from wrapping before the compare
    assign step_x = $signed(EXT_W'(stepsize_in));
    assign acc_x  = {{2{acc_q[ACC_W-1]}}, acc_q};
    assign lo_x   = {{2{lo_q[OUT_W-1]}}, lo_q, {FRAC_W{1'b0}}};
    assign hi_x   = {{2{hi_q[OUT_W-1]}}, hi_q, {FRAC_W{1'b0}}};
    assign up_x   = acc_x + step_x;
    assign dn_x   = acc_x - step_x;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        acc_sync_d = 1'b0;
        case (state_q)
            IDLE: begin
                acc_d = min_acc;
                lo_d  = minval_in;
                hi_d  = maxval_in;
                if (on_in && cfg_ok) begin
                    state_d    = UP;
                    acc_sync_d = 1'b1;
                end
            end
            UP: begin
                if (!on_in) begin
                    state_d = IDLE;
                    acc_d   = min_acc;
                end else if (acc_q == hi_acc) begin
                    // hi was clamped last cycle in sawtooth: wrap to lo now
                    lo_d  = minval_in;
                    hi_d  = maxval_in;
                    acc_d = min_acc;
                    if (cfg_ok) begin
                        acc_sync_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (up_x >= hi_x) begin
                    acc_d = hi_acc;
                    if (mode_in) begin
                        state_d = DOWN;
                    end
                end else begin
                    acc_d = up_x[ACC_W-1:0];
                end
            end
            DOWN: begin
                if (!on_in) begin
                    state_d = IDLE;
                    acc_d   = min_acc;
                end else if (dn_x <= lo_x) begin
                    lo_d  = minval_in;
                    hi_d  = maxval_in;
                    acc_d = min_acc;
                    if (cfg_ok) begin
                        state_d    = UP;
                        acc_sync_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    acc_d = dn_x[ACC_W-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs lag the accumulator by one register; active tracks the sample
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            acc_sync_q <= 1'b0;
            signal_out <= '0;
            sync_out   <= 1'b0;
            active_out <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            acc_sync_q <= acc_sync_d;
            signal_out <= acc_q[ACC_W-1:FRAC_W];
            sync_out   <= acc_sync_q;
            active_out <= (state_q != IDLE);
        end
    end

endmodule

// File: tb/tb_dac_ramp_gen.sv
// Directed test of dac_ramp_gen ramps, bounds, disable and reset.
// Expected samples are hand-computed tables.
module tb_dac_ramp_gen;

    logic               clk = 1'b0;
    logic               rst;
    logic               on;
    logic               mode;
    logic signed [15:0] minv;
    logic signed [15:0] maxv;
    logic [31:0]        step;
    logic signed [15:0] signal_out;
    logic               sync_out;
    logic               active_out;

    int n_chk  = 0;
    int n_pass = 0;

    int saw [8] = '{0, 1, 2, 3, 4, 0, 1, 2};
    int tri_w [8] = '{-2, 0, 2, 0, -2, 0, 2, 0};
    int dn_w [5] = '{-4, -2, 0, 2, 4};

    dac_ramp_gen #(
        .OUT_W (16),
        .FRAC_W(16)
    ) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .on_in      (on),
        .mode_in    (mode),
        .minval_in  (minv),
        .maxval_in  (maxv),
        .stepsize_in(step),
        .signal_out (signal_out),
        .sync_out   (sync_out),
        .active_out (active_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic restart;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst  = 1'b1;
        on   = 1'b1;
        mode = 1'b0;
        minv = 16'sd0;
        maxv = 16'sd4;
        step = 32'h0001_0000;
        tick();
        tick();
        check("rst_sig", signal_out, 0);
        check("rst_sync", sync_out, 0);
        check("rst_act", active_out, 0);

        rst = 1'b0;
        tick();
        check("idle_act", active_out, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("saw_sig", signal_out, saw[i]);
            check("saw_sync", sync_out, saw[i] == 0);
            check("saw_act", active_out, 1);
        end

        mode = 1'b1;
        minv = -16'sd2;
        maxv = 16'sd2;
        step = 32'h0002_0000;
        restart();
        for (int i = 0; i < 8; i++) begin
            tick();
            check("tri_sig", signal_out, tri_w[i]);
            check("tri_sync", sync_out, tri_w[i] == -2);
        end

        mode = 1'b0;
        minv = 16'sd0;
        maxv = 16'sh7FFF;
        step = 32'h0000_4000;
        restart();
        for (int i = 0; i < 16; i++) begin
            tick();
            check("frac_sig", signal_out, i / 4);
            check("frac_sync", sync_out, i == 0);
        end

        minv = 16'sd5;
        maxv = 16'sd5;
        step = 32'h0001_0000;
        restart();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bad_sig", signal_out, 5);
            check("bad_act", active_out, 0);
            check("bad_sync", sync_out, 0);
        end

        minv = 16'sd0;
        maxv = 16'sd4;
        restart();
        tick();
        tick();
        check("zs_pre", signal_out, 1);
        step = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("zs_sig", signal_out, 2);
            check("zs_sync", sync_out, 0);
            check("zs_act", active_out, 1);
        end

        minv = 16'sd1;
        maxv = 16'sd5;
        step = 32'h0001_0000;
        restart();
        tick();
        tick();
        tick();
        check("dis_pre", signal_out, 3);
        on = 1'b0;
        tick();
        check("dis_sig1", signal_out, 4);
        check("dis_act1", active_out, 1);
        tick();
        check("dis_sig2", signal_out, 1);
        check("dis_act2", active_out, 0);
        check("dis_sync", sync_out, 0);
        on = 1'b1;

        mode = 1'b1;
        minv = -16'sd4;
        maxv = 16'sd4;
        step = 32'h0002_0000;
        restart();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("dn_sig", signal_out, dn_w[i]);
        end
        rst = 1'b1;
        tick();
        check("mrst_sig", signal_out, 0);
        check("mrst_act", active_out, 0);
        check("mrst_sync", sync_out, 0);
        rst = 1'b0;

        minv = -16'sd32768;
        maxv = 16'sd32767;
        step = 32'hFFFF_FFFF;
        for (int m = 0; m < 2; m++) begin
            mode = (m == 1);
            restart();
            for (int i = 0; i < 6; i++) begin
                tick();
                check("ovf_sig", signal_out,
                      (i % 2 == 0) ? -32768 : 32767);
                check("ovf_sync", sync_out, i % 2 == 0);
                check("ovf_act", active_out, 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
